// File: rtl/nebula_pkg.sv
// Shared NoC types and constants for the Nebula NIU blocks.
package nebula_pkg;

   localparam int QOS_WIDTH        = 4;
   localparam int INJ_STARVE_CNT_W = 8;

   typedef struct packed {
      logic [7:0]  dst_id;
      logic [23:0] payload;
   } noc_flit_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      LOCKED = 2'd2
   } inj_arb_state_e;

endpackage

// File: rtl/nebula_rr_prio_pick.sv
// Combinational round-robin picker: first eligible requester after rr_ptr_i,
// returned as one-hot and index.
module nebula_rr_prio_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         eligible_i,
   input  logic [$clog2(N)-1:0] rr_ptr_i,
   output logic [N-1:0]         onehot_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);
   localparam int IW = $clog2(N);

   always_comb begin
      int c;
      c        = 0;
      onehot_o = '0;
      idx_o    = '0;
      any_o    = 1'b0;
      for (int k = 1; k <= N; k++) begin
         c = (int'(rr_ptr_i) + k) % N;
         if (!any_o && eligible_i[c]) begin
            any_o       = 1'b1;
            onehot_o[c] = 1'b1;
            idx_o       = IW'(c);
         end
      end
   end

endmodule

// File: rtl/nebula_niu_inject_arb.sv
// NIU injection-port arbiter: QoS first, then round-robin, with starvation override
// and wormhole locking. Statistics counters exist only with NEBULA_INJECT_ARB_STATS_EN.
module nebula_niu_inject_arb
   import nebula_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int QOS_W        = QOS_WIDTH,
   parameter int STARVE_LIMIT = 16,
   parameter int CNT_W        = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  noc_flit_t [NUM_REQ-1:0]       req_flit,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ-1:0][QOS_W-1:0] req_qos,
   output logic                          out_valid,
   input  logic                          out_ready,
   output noc_flit_t                     out_flit,
   output logic                          out_last,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          lock_active,
   output logic [NUM_REQ-1:0]            starve_flag
`ifdef NEBULA_INJECT_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][CNT_W-1:0] stat_flits,
   output logic [NUM_REQ-1:0][CNT_W-1:0] stat_pkts,
   output logic [CNT_W-1:0]              stat_starve_grants
`endif
);
   localparam int              IDX_W    = $clog2(NUM_REQ);
   localparam int              WC_W     = INJ_STARVE_CNT_W;
   localparam logic [WC_W-1:0] WC_MAX   = '1;
   localparam logic [WC_W-1:0] LIMIT    = WC_W'(STARVE_LIMIT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255 || CNT_W < 1)
   begin : g_bad_params
      $error("nebula_niu_inject_arb: parameter out of range");
   end

   inj_arb_state_e               state_q, state_d;
   logic [IDX_W-1:0]             lock_id_q, lock_id_d;
   logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]             grant_id_q, grant_id_d;
   logic [QOS_W-1:0]             hold_qos_q, hold_qos_d;
   logic [NUM_REQ-1:0][WC_W-1:0] wait_q, wait_d;

   logic [QOS_W-1:0]   max_qos;
   logic [NUM_REQ-1:0] starved_elig, prio_elig, pick_mask, pick_onehot, head_hs;
   logic [IDX_W-1:0]   pick_idx, sel;
   logic               pick_any, offer, hs, is_head;

   always_comb begin
      max_qos = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && req_qos[i] > max_qos) max_qos = req_qos[i];
      end
   end

   assign is_head   = (state_q != LOCKED);
   assign pick_mask = (|starved_elig) ? starved_elig : prio_elig;

   nebula_rr_prio_pick #(.N(NUM_REQ)) u_pick (
      .eligible_i (pick_mask),
      .rr_ptr_i   (rr_ptr_q),
      .onehot_o   (pick_onehot),
      .idx_o      (pick_idx),
      .any_o      (pick_any)
   );

   // Selection only moves in IDLE; HOLD and LOCKED pin the mux to lock_id.
   assign sel       = (state_q == IDLE) ? pick_idx : lock_id_q;
   assign offer     = (state_q == IDLE) ? pick_any : req_valid[sel];
   assign out_valid = rst_n & offer;
   assign hs        = out_valid & out_ready;
   assign out_flit  = out_valid ? req_flit[sel] : '0;
   assign out_last  = out_valid & req_last[sel];

   assign grant_id    = grant_id_q;
   assign lock_active = (state_q == LOCKED);

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic owner;
      assign owner             = (state_q == LOCKED) && (lock_id_q == IDX_W'(gi));
      assign starve_flag[gi]   = (wait_q[gi] >= LIMIT);
      assign starved_elig[gi]  = req_valid[gi] & starve_flag[gi];
      assign prio_elig[gi]     = req_valid[gi] && (req_qos[gi] == max_qos);
      assign head_hs[gi]       = hs && is_head && (sel == IDX_W'(gi));
      assign req_ready[gi]     = rst_n && out_ready &&
                                 ((state_q == IDLE) ? pick_onehot[gi] : (lock_id_q == IDX_W'(gi)));
      // The lock owner is being served, so it does not accumulate wait time.
      assign wait_d[gi] = (!req_valid[gi] || head_hs[gi] || owner) ? '0 :
                          (wait_q[gi] == WC_MAX) ? WC_MAX : wait_q[gi] + 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      lock_id_d  = lock_id_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      hold_qos_d = hold_qos_q;
      case (state_q)
         IDLE, HOLD: begin
            if (hs) begin
               rr_ptr_d   = sel;
               grant_id_d = sel;
               lock_id_d  = sel;
               state_d    = req_last[sel] ? IDLE : LOCKED;
            end else if (out_valid) begin
               state_d   = HOLD;
               lock_id_d = sel;
               if (state_q == IDLE) hold_qos_d = req_qos[sel];
            end
         end
         LOCKED: begin
            if (hs && req_last[sel]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lock_id_q  <= '0;
         rr_ptr_q   <= LAST_IDX;
         grant_id_q <= '0;
         hold_qos_q <= '0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         lock_id_q  <= lock_id_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         hold_qos_q <= hold_qos_d;
         wait_q     <= wait_d;
      end
   end

   hold_qos_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == HOLD && req_valid[lock_id_q]) |-> (req_qos[lock_id_q] == hold_qos_q));

`ifdef NEBULA_INJECT_ARB_STATS_EN
   // A held head keeps the starvation status it had when it was selected.
   logic hold_starve_q, hold_starve_d, starve_win;
   assign starve_win    = (state_q == IDLE) ? (|starved_elig) : hold_starve_q;
   assign hold_starve_d = starve_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_starve_q      <= 1'b0;
         stat_flits         <= '0;
         stat_pkts          <= '0;
         stat_starve_grants <= '0;
      end else begin
         hold_starve_q <= hold_starve_d;
         if (hs && is_head && starve_win) stat_starve_grants <= stat_starve_grants + 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (hs && sel == IDX_W'(i)) begin
               stat_flits[i] <= stat_flits[i] + 1'b1;
               if (req_last[i]) stat_pkts[i] <= stat_pkts[i] + 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_nebula_niu_inject_arb.sv
// Bench for nebula_niu_inject_arb: directed round-robin/starvation/reset cases plus
// random traffic checked every cycle against a packet-level reference model.
module tb_nebula_niu_inject_arb;
   import nebula_pkg::*;

   localparam int N           = 4;
   localparam int QW          = QOS_WIDTH;
   localparam int LIM         = 4;
   localparam int IW          = $clog2(N);
   localparam int RAND_CYCLES = 1500;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N-1:0]         req_valid, req_ready, req_last, starve_flag;
   noc_flit_t [N-1:0]    req_flit;
   logic [N-1:0][QW-1:0] req_qos;
   logic                 out_valid, out_ready, out_last, lock_active;
   noc_flit_t            out_flit;
   logic [IW-1:0]        grant_id;

   int errors = 0;
   int checks = 0;

   // reference model: owner of the port (-1 none), whether its head was accepted
   int m_owner, m_rr, m_grant;
   bit m_locked;
   int m_wait[N];
   int e_sel;
   bit e_valid;
   bit c_hs;
   int c_id;

   // random sources
   int s_rem[N];
   bit s_pend[N];
   int s_qos[N];
   int seq;
   int rr_exp[4] = '{0, 1, 2, 0};

   always #5 clk = ~clk;

   nebula_niu_inject_arb #(
      .NUM_REQ(N), .QOS_W(QW), .STARVE_LIMIT(LIM), .CNT_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_flit(req_flit),
      .req_last(req_last), .req_qos(req_qos),
      .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
      .out_last(out_last), .grant_id(grant_id), .lock_active(lock_active),
      .starve_flag(starve_flag)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner  = -1;
      m_locked = 1'b0;
      m_rr     = N - 1;
      m_grant  = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
   endtask

   // Arbitration rule: starved valid requesters first, else highest qos, tie by rotation.
   task automatic model_eval();
      int maxq;
      bit starv;
      int c;
      e_sel = -1;
      if (m_owner >= 0) e_sel = m_owner;
      else begin
         maxq  = -1;
         starv = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
               if (m_wait[i] >= LIM) starv = 1'b1;
               if (int'(req_qos[i]) > maxq) maxq = int'(req_qos[i]);
            end
         end
         for (int k = 1; k <= N; k++) begin
            c = (m_rr + k) % N;
            if (e_sel < 0 && req_valid[c] &&
                (starv ? (m_wait[c] >= LIM) : (int'(req_qos[c]) == maxq))) e_sel = c;
         end
      end
      e_valid = (e_sel >= 0) && req_valid[e_sel];
   endtask

   task automatic check_outputs();
      logic [N-1:0] e_ready, e_starve;
      model_eval();
      e_ready = '0;
      if (e_sel >= 0 && out_ready) e_ready[e_sel] = 1'b1;
      for (int i = 0; i < N; i++) e_starve[i] = (m_wait[i] >= LIM);
      check_eq("out_valid", out_valid, e_valid);
      check_eq("req_ready", req_ready, e_ready);
      if (e_valid) begin
         check_eq("out_flit", out_flit, req_flit[e_sel]);
         check_eq("out_last", out_last, req_last[e_sel]);
      end
      check_eq("grant_id", grant_id, m_grant);
      check_eq("lock_active", lock_active, m_locked);
      check_eq("starve_flag", starve_flag, e_starve);
   endtask

   task automatic model_update();
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i]) m_wait[i] = 0;
         else if (c_hs && c_id == i && !m_locked) m_wait[i] = 0;
         else if (m_locked && m_owner == i) m_wait[i] = 0;
         else if (m_wait[i] < 255) m_wait[i]++;
      end
      if (!m_locked) begin
         if (c_hs) begin
            m_rr    = c_id;
            m_grant = c_id;
            if (req_last[c_id]) m_owner = -1;
            else begin
               m_owner  = c_id;
               m_locked = 1'b1;
            end
         end else if (e_valid) m_owner = e_sel;
      end else if (c_hs && req_last[c_id]) begin
         m_owner  = -1;
         m_locked = 1'b0;
      end
   endtask

   // Called at posedge+1 with inputs driven; returns at the next posedge+1.
   task automatic cycle();
      #3;
      check_outputs();
      c_hs = e_valid && out_ready;
      c_id = e_sel;
      @(posedge clk);
      if (c_hs)
         $display("xfer req%0d flit=%h last=%0d qos=%0d", c_id, req_flit[c_id],
                  req_last[c_id], req_qos[c_id]);
      model_update();
      #1;
   endtask

   task automatic present_flit(input int i, input bit last, input int qos);
      noc_flit_t f;
      f.dst_id     = 8'(i);
      f.payload    = 24'(seq);
      seq++;
      req_flit[i]  = f;
      req_last[i]  = last;
      req_qos[i]   = QW'(qos);
      req_valid[i] = 1'b1;
   endtask

   task automatic drive_random(input int p);
      for (int i = 0; i < N; i++) begin
         if (c_hs && c_id == i) begin
            s_pend[i] = 1'b0;
            s_rem[i]--;
         end
         if (!s_pend[i]) begin
            if (int'($urandom_range(99)) < p) begin
               if (s_rem[i] == 0) begin
                  s_rem[i] = ($urandom_range(1) == 0) ? 1 : int'($urandom_range(4, 2));
                  s_qos[i] = int'($urandom_range(3));
               end
               present_flit(i, s_rem[i] == 1, s_qos[i]);
               s_pend[i] = 1'b1;
            end else req_valid[i] = 1'b0;
         end
      end
      out_ready = (int'($urandom_range(99)) < 75);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_last  = '1;
      req_qos   = '0;
      req_flit  = '0;
      out_ready = 1'b1;
      seq       = 0;
      c_hs      = 1'b0;
      c_id      = -1;
      model_reset();
      #2;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_req_ready", req_ready, '0);
      check_eq("rst_out_flit", out_flit, '0);
      check_eq("rst_out_last", out_last, 1'b0);
      check_eq("rst_grant_id", grant_id, '0);
      check_eq("rst_lock_active", lock_active, 1'b0);
      check_eq("rst_starve_flag", starve_flag, '0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // equal-qos single-flit heads rotate 0,1,2,0 without bubbles
      present_flit(0, 1'b1, 0);
      present_flit(1, 1'b1, 0);
      present_flit(2, 1'b1, 0);
      for (int k = 0; k < 4; k++) begin
         #1 check_eq("rr_grant", out_flit.dst_id, rr_exp[k]);
         cycle();
         present_flit(c_id, 1'b1, 0);
      end
      req_valid = '0;
      cycle();
      cycle();

      // high-qos stream starves req1 until its wait reaches the limit
      present_flit(0, 1'b1, 15);
      present_flit(1, 1'b1, 0);
      for (int k = 0; k < 5; k++) begin
         #1 check_eq("starve_grant", out_flit.dst_id, (k < 4) ? 0 : 1);
         if (k == 4) check_eq("starve_flag1", starve_flag[1], 1'b1);
         cycle();
         if (c_id == 0) present_flit(0, 1'b1, 15);
         else req_valid[1] = 1'b0;
      end
      #1 check_eq("starve_clear", starve_flag[1], 1'b0);
      req_valid = '0;
      cycle();
      cycle();

      // random traffic: multi-flit packets, bubbles, backpressure
      for (int i = 0; i < N; i++) begin
         s_rem[i]  = 0;
         s_pend[i] = 1'b0;
         s_qos[i]  = 0;
      end
      c_hs = 1'b0;
      for (int n = 0; n < RAND_CYCLES; n++) begin
         drive_random(60);
         cycle();
      end

      // reset in the middle of a 3-flit packet
      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      present_flit(0, 1'b0, 0);
      present_flit(1, 1'b1, 0);
      cycle();
      present_flit(0, 1'b0, 0);
      #1 check_eq("lock_before_rst", lock_active, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", out_valid, 1'b0);
      check_eq("midrst_lock_active", lock_active, 1'b0);
      check_eq("midrst_req_ready", req_ready, '0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      present_flit(0, 1'b1, 0);
      #1 check_eq("post_rst_grant", out_flit.dst_id, 0);
      cycle();
      if (c_hs && c_id == 0) req_valid[0] = 1'b0;
      cycle();
      req_valid = '0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nebula_niu_inject_arb.md
Name: nebula_niu_inject_arb

Overview:
Arbitrates NUM_REQ flit sources onto the single NIU NoC injection port (noc_flit_out_*). Sources are the AXI-NoC bridge request path, the bridge response path, the local-access responder and a future DMA engine.
Uses wormhole packet locking, so flits of different packets never interleave on the port. Selection is QoS-priority first, then round-robin, with a starvation override.
Sits between the sources and the router local port; the datapath is a zero-latency mux with registered grant state.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
QOS_W, 4, width of per-requester QoS field
STARVE_LIMIT, 16, wait cycles after which a requester is forced eligible (1..255)
CNT_W, 32, statistics counter width (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester flit valid
req_ready  out  NUM_REQ  per-requester flit accept
req_flit  in  NUM_REQ x noc_flit_t  per-requester flit
req_last  in  NUM_REQ  flit is packet tail; single-flit packet has last=1 on head
req_qos  in  NUM_REQ x QOS_W  priority, sampled on head flits only; higher wins
out_valid  out  1  to noc_flit_out_valid
out_ready  in  1  from noc_flit_out_ready
out_flit  out  noc_flit_t  to noc_flit_out
out_last  out  1  tail marker of forwarded flit
grant_id  out  $clog2(NUM_REQ)  current/last granted requester
lock_active  out  1  high while a multi-flit packet is in flight
starve_flag  out  NUM_REQ  requester wait counter >= STARVE_LIMIT

Behaviour:
- Reset is asynchronous, active-low: reset rst_n, asynchronous, active-low; clock clk. Reset values:
  - state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first tie), grant_id=0, lock_active=0, wait counters=0.
  - out_valid=0, req_ready=0, out_flit='0, out_last=0.
- States:
  - IDLE: no flit offered.
  - HOLD: head offered but not accepted; grant frozen.
  - LOCKED: mid-packet; grant fixed until the tail.
- Selection (combinational, IDLE only):
  - Eligible set = requesters with valid=1.
  - If any eligible requester is starved, restrict the set to starved ones.
  - Otherwise restrict to those with maximal req_qos.
  - Pick the first in the set searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
- Datapath: out_valid/out_flit/out_last = mux(sel). req_ready[sel]=out_ready; all other req_ready=0. Zero added latency.
- IDLE transitions:
  - Head handshake with last=1: stay IDLE, rr_ptr<=sel, grant_id<=sel.
  - Head handshake with last=0: go LOCKED, lock_id<=sel, rr_ptr<=sel, lock_active<=1.
  - out_valid && !out_ready: go HOLD, lock_id<=sel. The output must not switch source while valid is held.
- HOLD: mux fixed to lock_id. On handshake, go IDLE or LOCKED per last, as above.
- LOCKED: mux fixed to lock_id.
  - Tail handshake: go IDLE, lock_active<=0.
  - A locked requester dropping valid mid-packet creates a bubble; the lock is held with no timeout.
- Higher-QoS or starved arrivals never preempt HOLD or LOCKED.
- Wait counters, per requester:
  - Increment, saturating at 255, when valid=1 and its head is not accepted this cycle.
  - Clear on its head handshake or when valid=0.
  - starve_flag[i] = (wait[i] >= STARVE_LIMIT).
- Simultaneous events:
  - Tail handshake plus new valids in the same cycle: the next selection happens the following cycle from IDLE.
  - Bubble-free back-to-back single-flit packets from different requesters are allowed.
- Reset mid-packet: lock is dropped immediately; packet integrity is the router's concern after a global reset.
- Assertion (simulation only): a requester asserting valid with different qos across a held head is flagged.

Optional Feature:
- Macro NEBULA_INJECT_ARB_STATS_EN.
- Defined:
  - Adds output stat_flits [NUM_REQ] x CNT_W, counting accepted flits per requester.
  - Adds stat_pkts [NUM_REQ] x CNT_W, counting tails accepted.
  - Adds stat_starve_grants CNT_W, counting head grants won via the starvation override.
  - All counters wrap and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- nebula_pkg holds the shared items:
  - inj_arb_state_e {IDLE, HOLD, LOCKED}
  - INJ_STARVE_CNT_W=8
  - reuse of noc_flit_t and QOS_WIDTH
- One sub-module is natural: nebula_rr_prio_pick. It is a combinational masked round-robin picker (eligible mask, rr_ptr -> one-hot plus index), reusable by router output arbiters.

Test Plan:
- Single-flit heads: req 0,1,2 valid, equal qos=0, out_ready=1 -> grants 0,1,2,0 on consecutive cycles; no bubbles.
- QoS: req1 qos=3, req2 qos=7, both valid -> req2 granted first; req1 after req2 drops valid.
- Wormhole: req0 sends a 4-flit packet with out_ready toggling 1,0,1,1,0,1 while req1 (qos=15) is valid.
  - Required: the 4 req0 flits appear contiguously, lock_active=1 until the tail handshake, then req1 is granted.
- HOLD: req0 head offered, out_ready=0 for 5 cycles, req3 raises higher qos -> out_flit stays req0's; req_ready[3]=0 throughout.
- Starvation, STARVE_LIMIT=4: req0 qos=15 streams continuously; req1 qos=0 is valid.
  - Required: starve_flag[1]=1 after 4 wait cycles; req1 is granted at the next IDLE selection; its counter clears to 0.
- Reset: assert rst_n=0 while LOCKED at flit 2 of 3 -> out_valid=0, lock_active=0, all req_ready=0 immediately. After release, req0 is granted first.
